// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//   Direct-mapped data cache. Each line holds one word. Stores are
//   write-through and do not allocate. Word accesses that are not word-aligned
//   bypass the cache. Loads that miss stall the CPU until the line has been
//   fetched, and the following cycle then hits. Stores stall the CPU until
//   memory acknowledges the write.
//
// Ports
//   clk, rst_n      : clock; synchronous active-low reset
//   cpu_re, cpu_we  : load / store request (both high = store)
//   addr_mode       : 1 = byte access, 0 = word access
//   cpu_addr        : byte address
//   cpu_wd          : store data
//   cpu_rd          : load data (combinational on a hit)
//   stall           : CPU holds all inputs stable while this is high
//   mem_req/mem_we/mem_addr_mode/mem_addr/mem_wd : memory request (registered)
//   mem_rd, mem_ack : memory read data; one-cycle completion pulse
//   hit_count, miss_count : saturating load statistics
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic                     addr_mode,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wd,
    output logic [DATA_WIDTH-1:0]    cpu_rd,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_addr_mode,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    input  logic                     mem_ack,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_e;

    state_e                     state_q;
    logic [SETS-1:0]            valid_q;
    logic [DATA_WIDTH-1:0]      data_q [SETS];
    logic [TAG_W-1:0]           tag_q  [SETS];
    logic [15:0]                hit_cnt_q;
    logic [15:0]                miss_cnt_q;

    logic                       mem_req_q;
    logic                       mem_we_q;
    logic                       mem_mode_q;
    logic [ADDRESS_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wd_q;

    // Address decode and lookup (CPU inputs are stable for a whole request)
    logic [IDX_W-1:0]           index;
    logic [TAG_W-1:0]           tag;
    logic [1:0]                 byte_off;
    logic [DATA_WIDTH-1:0]      line;
    logic                       uncached;
    logic                       tag_hit;
    logic                       load_hit;
    logic                       fill_en;
    logic                       store_en;
    logic [DATA_WIDTH-1:0]      store_line_d;

    assign index    = cpu_addr[IDX_W+1:2];
    assign tag      = cpu_addr[ADDRESS_WIDTH-1:IDX_W+2];
    assign byte_off = cpu_addr[1:0];
    assign line     = data_q[index];
    // Misaligned word accesses go straight to memory and never touch a line.
    assign uncached = !addr_mode && (byte_off != 2'b00);
    assign tag_hit  = valid_q[index] && (tag_q[index] == tag);
    assign load_hit = cpu_re && !cpu_we && tag_hit && !uncached;

    assign fill_en  = (state_q == RD_MISS) && mem_ack && !uncached;
    assign store_en = (state_q == WR_THRU) && mem_ack && tag_hit && !uncached;

    // Line image after a store hit: byte merge or full-word replace.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        store_line_d = line;
        if (addr_mode) begin
            store_line_d[{byte_off, 3'b000} +: 8] = cpu_wd[7:0];
        end else begin
            store_line_d = cpu_wd;
        end
    end

    // CPU-side outputs are combinational so hits complete in the same cycle.
    always_comb begin
        stall  = 1'b0;
        cpu_rd = '0;
        unique case (state_q)
            IDLE: begin
                stall = cpu_we || (cpu_re && !load_hit);
                if (load_hit) begin
                    cpu_rd = addr_mode ? {{(DATA_WIDTH-8){1'b0}}, line[{byte_off, 3'b000} +: 8]}
                                       : line;
                end
            end
            RD_MISS: begin
                // An uncached load completes on the ack itself; a cached one
                // completes as a hit in the following IDLE cycle.
                stall = !(mem_ack && uncached);
                if (mem_ack && uncached) begin
                    cpu_rd = mem_rd;
                end
            end
            WR_THRU: begin
                // Release on the ack, otherwise the held store would re-issue.
                stall = !mem_ack;
            end
            default: begin
                stall  = 1'b0;
                cpu_rd = '0;
            end
        endcase
    end

    // Line data and tags: valid bits gate every use, so they need no reset.
    always_ff @(posedge clk) begin
        // NOTE: memory arrays are left out of reset; only the valid bits are cleared.
        if (fill_en) begin
            data_q[index] <= mem_rd;
            tag_q[index]  <= tag;
        end else if (store_en) begin
            data_q[index] <= store_line_d;
        end
    end

    // Controller: state, valid bits, statistics and registered memory request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_mode_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_we) begin
                        state_q    <= WR_THRU;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_mode_q <= addr_mode;
                        mem_addr_q <= cpu_addr;
                        mem_wd_q   <= cpu_wd;
                    end else if (cpu_re) begin
                        if (load_hit) begin
                            if (hit_cnt_q != 16'hFFFF) begin
                                hit_cnt_q <= hit_cnt_q + 16'd1;
                            end
                        end else begin
                            if (miss_cnt_q != 16'hFFFF) begin
                                miss_cnt_q <= miss_cnt_q + 16'd1;
                            end
                            state_q    <= RD_MISS;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_mode_q <= 1'b0;
                            mem_addr_q <= uncached ? cpu_addr
                                                   : {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                            mem_wd_q   <= '0;
                        end
                    end
                end
                RD_MISS, WR_THRU: begin
                    if (mem_ack) begin
                        if (fill_en) begin
                            valid_q[index] <= 1'b1;
                        end
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_mode_q <= 1'b0;
                        mem_addr_q <= '0;
                        mem_wd_q   <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr_mode = mem_mode_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wd        = mem_wd_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//   Directed bench for data_cache. A table of per-cycle vectors covers cold
//   miss, byte/word hits, write-through, store-only priority, no-allocate
//   conflicts, eviction and uncached access. Hand-written sequences cover reset
//   during a miss and hit-counter saturation.
// -----------------------------------------------------------------------------
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we, addr_mode;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic        stall;
    logic        mem_req, mem_we, mem_addr_mode;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_cache #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_re       (cpu_re),
        .cpu_we       (cpu_we),
        .addr_mode    (addr_mode),
        .cpu_addr     (cpu_addr),
        .cpu_wd       (cpu_wd),
        .cpu_rd       (cpu_rd),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_mode(mem_addr_mode),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .mem_ack      (mem_ack),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    // One cycle of stimulus plus the outputs expected at the following negedge
    // (counters show their value before this cycle's clock edge).
    typedef struct {
        logic        re, we, mode;
        logic [31:0] addr, wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic [31:0] e_rd;
        logic        e_req, e_mwe, e_mmode;
        logic [31:0] e_maddr, e_mwd;
        logic [15:0] e_hits, e_misses;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic re, input logic we, input logic mode,
        input logic [31:0] addr, input logic [31:0] wd,
        input logic ack, input logic [31:0] rdata,
        input logic e_stall, input logic [31:0] e_rd,
        input logic e_req, input logic e_mwe, input logic e_mmode,
        input logic [31:0] e_maddr, input logic [31:0] e_mwd,
        input logic [15:0] e_hits, input logic [15:0] e_misses);
        vec_t v;
        v.re = re; v.we = we; v.mode = mode; v.addr = addr; v.wd = wd;
        v.ack = ack; v.rdata = rdata; v.e_stall = e_stall; v.e_rd = e_rd;
        v.e_req = e_req; v.e_mwe = e_mwe; v.e_mmode = e_mmode;
        v.e_maddr = e_maddr; v.e_mwd = e_mwd; v.e_hits = e_hits; v.e_misses = e_misses;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic mode,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic ack, input logic [31:0] rdata);
        cpu_re = re; cpu_we = we; addr_mode = mode;
        cpu_addr = addr; cpu_wd = wd; mem_ack = ack; mem_rd = rdata;
    endtask

    task automatic check_mem_idle(input string tag);
        check({tag, " mem_req"},  {31'd0, mem_req},       32'd0);
        check({tag, " mem_we"},   {31'd0, mem_we},        32'd0);
        check({tag, " mem_mode"}, {31'd0, mem_addr_mode}, 32'd0);
        check({tag, " mem_addr"}, mem_addr,               32'd0);
        check({tag, " mem_wd"},   mem_wd,                 32'd0);
    endtask

    initial begin
        // re we md addr        wd          ack rdata      | stall rd        req mwe mmd maddr       mwd         hits misses
        vecs[0]  = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        1,32'h0,       0,0,0,32'h0,    32'h0,       0,0);
        vecs[1]  = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        1,32'h0,       1,0,0,32'h10000,32'h0,       0,1);
        vecs[2]  = mk(1,0,0,32'h10000,32'h0,       1,32'hDEADBEEF, 1,32'h0,       1,0,0,32'h10000,32'h0,       0,1);
        vecs[3]  = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        0,32'hDEADBEEF,0,0,0,32'h0,    32'h0,       0,1);
        vecs[4]  = mk(1,0,1,32'h10002,32'h0,       0,32'h0,        0,32'h000000AD,0,0,0,32'h0,    32'h0,       1,1);
        vecs[5]  = mk(0,1,1,32'h10001,32'h55,      0,32'h0,        1,32'h0,       0,0,0,32'h0,    32'h0,       2,1);
        vecs[6]  = mk(0,1,1,32'h10001,32'h55,      0,32'h0,        1,32'h0,       1,1,1,32'h10001,32'h55,      2,1);
        vecs[7]  = mk(0,1,1,32'h10001,32'h55,      1,32'h0,        0,32'h0,       1,1,1,32'h10001,32'h55,      2,1);
        vecs[8]  = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        0,32'hDEAD55EF,0,0,0,32'h0,    32'h0,       2,1);
        vecs[9]  = mk(1,1,0,32'h10020,32'h12345678,0,32'h0,        1,32'h0,       0,0,0,32'h0,    32'h0,       3,1);
        vecs[10] = mk(1,1,0,32'h10020,32'h12345678,1,32'h0,        0,32'h0,       1,1,0,32'h10020,32'h12345678,3,1);
        vecs[11] = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        0,32'hDEAD55EF,0,0,0,32'h0,    32'h0,       3,1);
        vecs[12] = mk(0,0,0,32'h0,    32'h0,       1,32'hFFFFFFFF, 0,32'h0,       0,0,0,32'h0,    32'h0,       4,1);
        vecs[13] = mk(1,0,0,32'h10020,32'h0,       0,32'h0,        1,32'h0,       0,0,0,32'h0,    32'h0,       4,1);
        vecs[14] = mk(1,0,0,32'h10020,32'h0,       1,32'hCAFEF00D, 1,32'h0,       1,0,0,32'h10020,32'h0,       4,2);
        vecs[15] = mk(1,0,0,32'h10020,32'h0,       0,32'h0,        0,32'hCAFEF00D,0,0,0,32'h0,    32'h0,       4,2);
        vecs[16] = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        1,32'h0,       0,0,0,32'h0,    32'h0,       5,2);
        vecs[17] = mk(1,0,0,32'h10000,32'h0,       1,32'hDEAD55EF, 1,32'h0,       1,0,0,32'h10000,32'h0,       5,3);
        vecs[18] = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        0,32'hDEAD55EF,0,0,0,32'h0,    32'h0,       5,3);
        vecs[19] = mk(1,0,0,32'h10001,32'h0,       0,32'h0,        1,32'h0,       0,0,0,32'h0,    32'h0,       6,3);
        vecs[20] = mk(1,0,0,32'h10001,32'h0,       1,32'h11223344, 0,32'h11223344,1,0,0,32'h10001,32'h0,       6,4);
        vecs[21] = mk(1,0,0,32'h10000,32'h0,       0,32'h0,        0,32'hDEAD55EF,0,0,0,32'h0,    32'h0,       6,4);
        vecs[22] = mk(1,0,1,32'h10003,32'h0,       0,32'h0,        0,32'h000000DE,0,0,0,32'h0,    32'h0,       7,4);
        vecs[23] = mk(0,0,0,32'h0,    32'h0,       0,32'h0,        0,32'h0,       0,0,0,32'h0,    32'h0,       8,4);

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset stall",  {31'd0, stall}, 32'd0);
        check("reset cpu_rd", cpu_rd,         32'd0);
        check("reset hits",   {16'd0, hit_count},  32'd0);
        check("reset misses", {16'd0, miss_count}, 32'd0);
        check_mem_idle("reset");

        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].re, vecs[i].we, vecs[i].mode, vecs[i].addr,
                     vecs[i].wd, vecs[i].ack, vecs[i].rdata);
            @(negedge clk);
            check($sformatf("v%0d stall", i),    {31'd0, stall},         {31'd0, vecs[i].e_stall});
            // Load data is only defined when a load completes.
            if (!vecs[i].e_stall && !vecs[i].we)
                check($sformatf("v%0d cpu_rd", i), cpu_rd, vecs[i].e_rd);
            check($sformatf("v%0d mem_req", i),  {31'd0, mem_req},       {31'd0, vecs[i].e_req});
            check($sformatf("v%0d mem_we", i),   {31'd0, mem_we},        {31'd0, vecs[i].e_mwe});
            check($sformatf("v%0d mem_mode", i), {31'd0, mem_addr_mode}, {31'd0, vecs[i].e_mmode});
            check($sformatf("v%0d mem_addr", i), mem_addr,               vecs[i].e_maddr);
            check($sformatf("v%0d mem_wd", i),   mem_wd,                 vecs[i].e_mwd);
            check($sformatf("v%0d hits", i),     {16'd0, hit_count},     {16'd0, vecs[i].e_hits});
            check($sformatf("v%0d misses", i),   {16'd0, miss_count},    {16'd0, vecs[i].e_misses});
        end

        // ---------------- reset in the middle of a miss ----------------
        @(posedge clk); #1 drive(1, 0, 0, 32'h10040, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("rstmiss enter stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 drive(1, 0, 0, 32'h10040, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("rstmiss mem_req",  {31'd0, mem_req}, 32'd1);
        check("rstmiss mem_addr", mem_addr,         32'h10040);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h12121212);  // late ack
        @(negedge clk);
        check("rstmiss stall",  {31'd0, stall},      32'd0);
        check("rstmiss cpu_rd", cpu_rd,              32'd0);
        check("rstmiss hits",   {16'd0, hit_count},  32'd0);
        check("rstmiss misses", {16'd0, miss_count}, 32'd0);
        check_mem_idle("rstmiss after");
        @(posedge clk); #1 drive(0, 0, 0, 32'h0, 32'h0, 1, 32'h12121212);
        @(negedge clk);
        check("late ack ignored mem_req", {31'd0, mem_req}, 32'd0);
        check("late ack ignored stall",   {31'd0, stall},   32'd0);
        // Line 0 was valid before the reset; it must miss now.
        @(posedge clk); #1 drive(1, 0, 0, 32'h10000, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("reload miss stall", {31'd0, stall},      32'd1);
        check("reload miss count", {16'd0, miss_count}, 32'd0);
        @(posedge clk); #1 drive(1, 0, 0, 32'h10000, 32'h0, 1, 32'hDEADBEEF);
        @(negedge clk);
        check("reload mem_req",    {31'd0, mem_req},    32'd1);
        check("reload mem_addr",   mem_addr,            32'h10000);
        check("reload miss count", {16'd0, miss_count}, 32'd1);
        @(posedge clk); #1 drive(1, 0, 0, 32'h10000, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("reload hit stall",  {31'd0, stall},     32'd0);
        check("reload hit data",   cpu_rd,             32'hDEADBEEF);
        check("reload hit count",  {16'd0, hit_count}, 32'd0);

        // ---------------- hit counter saturation ----------------
        // The load stays presented; every edge is another hit.
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat hits",   {16'd0, hit_count},  32'h0000FFFF);
        check("sat misses", {16'd0, miss_count}, 32'd1);
        check("sat stall",  {31'd0, stall},      32'd0);
        @(posedge clk);
        @(negedge clk);
        check("sat hold", {16'd0, hit_count}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
